// File: rtl/bcd_display_scanner.sv
// Purpose: holds a 3-digit BCD sum + carry and scans it onto a 4-digit 7-seg display; LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// Latency: hold/err update on the load edge; seg/an follow the held value and scan index one cycle later.
// Backpressure: none; load is accepted every cycle and the scan free-runs.
module bcd_display_scanner #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] S,
  input  logic        Cout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [11:0]   hold_s;
  logic          hold_c;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [6:0]    seg_nxt;
`ifdef LEADING_ZERO_BLANK_EN
  logic          lz2;
  logic          lz1;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_s <= 12'h000;
      hold_c <= 1'b0;
      err    <= 1'b0;
    end else if (load) begin
      hold_s <= S;
      hold_c <= Cout;
      err    <= (S[3:0] > 4'd9) | (S[7:4] > 4'd9) | (S[11:8] > 4'd9);
    end
  end

  // load never touches the scan counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    seg_nxt = 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    // invalid nibbles are nonzero, so they are never blanked
    lz2 = !hold_c && (hold_s[11:8] == 4'd0);
    lz1 = lz2 && (hold_s[7:4] == 4'd0);
    case (idx)
      2'd0:    seg_nxt = decode(hold_s[3:0]);
      2'd1:    seg_nxt = lz1 ? 7'h00 : decode(hold_s[7:4]);
      2'd2:    seg_nxt = lz2 ? 7'h00 : decode(hold_s[11:8]);
      default: seg_nxt = hold_c ? 7'h06 : 7'h00;
    endcase
`else
    case (idx)
      2'd0:    seg_nxt = decode(hold_s[3:0]);
      2'd1:    seg_nxt = decode(hold_s[7:4]);
      2'd2:    seg_nxt = decode(hold_s[11:8]);
      default: seg_nxt = hold_c ? 7'h06 : 7'h3F;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 4'b0001;
      seg <= 7'h3F;
    end else begin
      an  <= 4'b0001 << idx;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: two scanners (SCAN_DIV=4 and SCAN_DIV=1) share stimulus and are
// compared every cycle against an arithmetic model, plus literal expectations.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic        load;
  logic [11:0] S;
  logic        Cout;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic        err0, err1;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  bcd_display_scanner #(.SCAN_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .load(load), .S(S), .Cout(Cout),
    .seg(seg0), .an(an0), .err(err0)
  );

  bcd_display_scanner #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .S(S), .Cout(Cout),
    .seg(seg1), .an(an1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          md [2] = '{4, 1};
  int unsigned mcnt [2];
  logic [11:0] ms;
  logic        mc;
  logic        merr;
  bit          mvalid = 1'b0;
  logic [3:0]  ean [2];
  logic [6:0]  eseg [2];

  function automatic int nib_of(input logic [11:0] v, input int d);
    return int'((v >> (4 * d)) & 12'hF);
  endfunction

  function automatic logic [6:0] seg_of(input int n);
    return (n > 9) ? 7'h40 : SEG_TBL[n];
  endfunction

  // Display content of digit d given the currently held value.
  function automatic logic [6:0] digit_seg(input int d);
    bit blank;
    if (d == 3) return mc ? 7'h06 : (LZB ? 7'h00 : 7'h3F);
    blank = 1'b0;
    if (LZB && !mc && d > 0) begin
      blank = 1'b1;
      for (int j = d; j <= 2; j++)
        if (nib_of(ms, j) != 0) blank = 1'b0;
    end
    return blank ? 7'h00 : seg_of(nib_of(ms, d));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mvalid = 1'b1;
      ms = 12'h000; mc = 1'b0; merr = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0; ean[i] = 4'b0001; eseg[i] = 7'h3F;
      end
    end else if (mvalid) begin
      // digit shown now is the one active one edge earlier
      for (int i = 0; i < 2; i++) begin
        int d;
        d = int'((mcnt[i] / md[i]) % 4);
        ean[i]  = 4'(1 << d);
        eseg[i] = digit_seg(d);
        mcnt[i]++;
      end
      if (load) begin
        ms = S; mc = Cout;
        merr = (nib_of(S, 0) > 9) || (nib_of(S, 1) > 9) || (nib_of(S, 2) > 9);
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("an0", 32'(an0), 32'(ean[0]));
      check("seg0", 32'(seg0), 32'(eseg[0]));
      check("err0", 32'(err0), 32'(merr));
      check("an1", 32'(an1), 32'(ean[1]));
      check("seg1", 32'(seg1), 32'(eseg[1]));
      check("err1", 32'(err1), 32'(merr));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_load(input logic [11:0] v, input logic c);
    load = 1'b1; S = v; Cout = c;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an0(input logic [3:0] tgt, input string name);
    int k;
    k = 0;
    while (an0 !== tgt && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (an0 !== tgt) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting an0 got %b expected %b", name, an0, tgt);
    end
  endtask

  task automatic digit_is(input int d, input logic [6:0] exp, input string name);
    wait_an0(4'(1 << d), name);
    check(name, 32'(seg0), 32'(exp));
  endtask

  initial begin
    int n;
    logic [11:0] s;
    logic [3:0] exp_an [4];
    rst = 1'b0; load = 1'b0; S = 12'h000; Cout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an0), 32'h1);
    check("rst_seg", 32'(seg0), 32'h3F);
    check("rst_err", 32'(err0), 32'h0);
    rst = 1'b1;

    n = 0;
    @(negedge clk);
    while (an0 === 4'b0001 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("dwell_d0", 32'(n), 32'd4);
    check("advance_d1", 32'(an0), 32'h2);

    do_load(12'h579, 1'b0);
    check("err_579", 32'(err0), 32'h0);
    @(negedge clk);
    digit_is(0, 7'h6F, "579_d0");
    digit_is(1, 7'h07, "579_d1");
    digit_is(2, 7'h6D, "579_d2");
    digit_is(3, LZB ? 7'h00 : 7'h3F, "579_d3");

    do_load(12'h0A3, 1'b0);
    check("err_0A3", 32'(err0), 32'h1);
    @(negedge clk);
    digit_is(0, 7'h4F, "0A3_d0");
    digit_is(1, 7'h40, "0A3_d1");
    do_load(12'h123, 1'b0);
    check("err_clr", 32'(err0), 32'h0);

`ifdef LEADING_ZERO_BLANK_EN
    do_load(12'h008, 1'b0);
    @(negedge clk);
    digit_is(0, 7'h7F, "lz_d0");
    digit_is(1, 7'h00, "lz_d1");
    digit_is(2, 7'h00, "lz_d2");
    digit_is(3, 7'h00, "lz_d3");
    do_load(12'h008, 1'b1);
    @(negedge clk);
    digit_is(3, 7'h06, "lzc_d3");
    digit_is(0, 7'h7F, "lzc_d0");
    digit_is(1, 7'h3F, "lzc_d1");
    digit_is(2, 7'h3F, "lzc_d2");
`endif

    // reset mid-scan, colliding with a load
    do_load(12'h456, 1'b1);
    wait_an0(4'b0100, "mid_wait");
    rst = 1'b0; load = 1'b1; S = 12'h999; Cout = 1'b1;
    @(negedge clk);
    check("mid_rst_an", 32'(an0), 32'h1);
    check("mid_rst_seg", 32'(seg0), 32'h3F);
    check("mid_rst_err", 32'(err0), 32'h0);
    rst = 1'b1; load = 1'b0;
    @(negedge clk);
    check("held_lost", 32'(seg0), 32'h3F);

    // SCAN_DIV=1: wrap with no idle cycle
    exp_an = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n = 0;
    while (an1 !== 4'b0001 && n < 8) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_an1", 32'(an1), 32'(exp_an[i]));
    end

    // SCAN_DIV=1: new value visible one edge after load
    do_load(12'h456, 1'b1);
    @(negedge clk);
    case (an1)
      4'b0001: check("lat_d0", 32'(seg1), 32'h7D);
      4'b0010: check("lat_d1", 32'(seg1), 32'h6D);
      4'b0100: check("lat_d2", 32'(seg1), 32'h66);
      default: check("lat_d3", 32'(seg1), 32'h06);
    endcase

    for (int c = 0; c < 2500; c++) begin
      rst  = ($urandom_range(0, 199) != 0);
      load = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < 3; j++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3)       s[j*4 +: 4] = 4'd0;
        else if (r == 9) s[j*4 +: 4] = 4'($urandom_range(10, 15));
        else             s[j*4 +: 4] = 4'($urandom_range(0, 9));
      end
      S = s;
      Cout = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the registered 3-digit BCD adder: captures the 12-bit BCD sum and carry-out on a load strobe, holds them, and drives a time-multiplexed 4-digit common 7-segment display. Digits 0-2 show the sum nibbles (digit 0 = least significant). Digit 3 shows the carry-out. A prescaler sets the per-digit dwell time. Any captured nibble greater than 9 is flagged and shown as a dash.

## Interface
- SCAN_DIV, 4, clock cycles each digit stays active; legal range >= 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- load  in  1  capture strobe; when high, S and Cout are captured on that rising edge.
- S  in  12  BCD sum from the adder stage; [3:0] = digit 0, [7:4] = digit 1, [11:8] = digit 2.
- Cout  in  1  carry-out from the adder stage.
- seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- an  out  4  digit enable, one-hot, active-high; an[i] selects digit i.
- err  out  1  high while the held value contains a nibble > 9.

## Operation
- Hold register: 12-bit sum plus 1-bit carry. Loaded when load=1. It keeps its value otherwise.
- err is registered together with the hold register: set to the OR over the three nibbles of (nibble > 9) evaluated on the captured S. It stays unchanged until the next load.
- Prescaler cnt counts 0 … SCAN_DIV-1. When cnt = SCAN_DIV-1, cnt returns to 0 and digit index idx advances 0→1→2→3→0. With SCAN_DIV=1, idx advances every cycle.
- Output register updates every cycle:
  - an is set to onehot(idx).
  - seg is set to the decode of digit idx, using the current hold register.
- Decode, seg[6:0] hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibble > 9 gives 40 (dash). Blank is 00.
- Digit 3: 06 when held carry = 1. When held carry = 0, the value is set by Configuration.
- load does not disturb cnt or idx.

## Timing
- Reset (rst=0 at an edge) sets:
  - hold = 0, carry = 0, err = 0;
  - cnt = 0, idx = 0;
  - an = 4'b0001, seg = 7'h3F.
- rst=0 overrides load on the same edge.
- Load latency:
  - load high at edge k: hold and err are updated at edge k.
  - seg/an reflect the new value from edge k+1, for whichever digit is active.
- Output lag: an/seg lag idx by one cycle. After idx changes at edge k, an/seg show the new digit from edge k+1.
- After reset is released, each digit is active for exactly SCAN_DIV cycles. Full scan period = 4·SCAN_DIV cycles.
- Wrap-around: idx 3→0 happens with no idle cycle.
- Reset mid-scan: the scan restarts at digit 0 on the reset edge. The held value is lost.
- Back-to-back loads: each load overwrites the hold register. The last load wins.

## Configuration
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit 3 is blank (00) when carry = 0.
  - Digit 2 is blank when carry = 0 and nibble2 = 0.
  - Digit 1 is blank when digit 2 is blanked and nibble1 = 0.
  - Digit 0 is never blanked.
  - An invalid nibble (> 9) counts as nonzero for blanking.
- Undefined:
  - Digit 3 shows 3F when carry = 0.
  - Digits 0-2 always show their decoded value. No blanking.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release → an=0001, seg=3F, err=0. idx then advances after 4 cycles (SCAN_DIV=4).
- Load S=12'h579, Cout=0 → digit0 seg=6F, digit1 seg=07, digit2 seg=6D, digit3 seg=00 (macro) / 3F (no macro). Each digit is held for 4 cycles. err=0.
- Load S=12'h0A3, Cout=0 → err=1 from the load edge. Digit1 seg=40, digit0 seg=4F. A following load of S=12'h123 clears err.
- Macro defined:
  - Load S=12'h008, Cout=0 → digits 3, 2, 1 show 00; digit0 shows 7F.
  - Then load S=12'h008, Cout=1 → digit3=06, digit2=3F, digit1=3F.
- Reset mid-scan with idx=2 and a nonzero held value → next edge gives an=0001, seg=3F, err=0. Reset asserted together with load → reset wins.
- Wrap and latency (SCAN_DIV=1): an cycles 0001→0010→0100→1000→0001 on consecutive cycles. With load at edge k, the new digit value appears on seg at edge k+1.
